// File: rtl/uart_rx_sniffer.sv
// uart_rx_sniffer: 8N1 UART receiver that listens on a serial TX line.
// Recovers bytes with a fixed clocks-per-bit counter and mid-bit sampling,
// and queues them in a first-word-fall-through FIFO read via valid/ready.
// Optional even-parity bit support is enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps

module uart_rx_sniffer #(
  parameter int BIT_CLKS   = 32'sd16,
  parameter int FIFO_DEPTH = 32'sd8
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_rxd,
  output logic [7:0]                  o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_frame_err,
  output logic                        o_overflow,
  output logic                        o_parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 32'sd1;
  localparam int TW = $clog2(BIT_CLKS);

  localparam logic [TW-1:0] CTR_ZERO   = TW'(1'b0);
  localparam logic [TW-1:0] CTR_ONE    = TW'(1'b1);
  localparam logic [TW-1:0] CTR_LAST   = TW'(BIT_CLKS - 32'sd1);
  localparam logic [TW-1:0] CTR_SAMPLE = TW'(BIT_CLKS / 32'sd2 - 32'sd1);
  localparam logic [AW-1:0] PTR_ZERO   = AW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_BRK    = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

`ifdef UART_RX_PARITY_EN
  // Returns 1 when the data byte plus the received parity bit is not even parity
  function automatic logic parity_bad(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  // Line synchronizer and "line seen high since reset" tracking
  logic          rx_meta_r;
  logic          rx_r;
  logic [1:0]    sync_vld_r;
  logic          armed_r;

  // Frame recovery
  logic [2:0]    state_r, state_nxt_s;
  logic [TW-1:0] ctr_r, ctr_nxt_s, ctr_inc_s;
  logic [2:0]    bit_r, bit_nxt_s;
  logic [7:0]    sr_r, sr_nxt_s;
  logic          sample_s, wrap_s;
  logic          push_req_s, frame_err_s;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_r, par_bad_nxt_s;
  logic          par_err_s;
`endif

  // Byte FIFO
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          full_s, pop_s, push_s, ovf_s;
  logic [7:0]    head_nxt_s;
  logic [7:0]    data_r;
  logic          valid_r, frame_err_r, overflow_r;
`ifdef UART_RX_PARITY_EN
  logic          parity_err_r;
`endif

  assign sample_s  = (ctr_r == CTR_SAMPLE);
  assign wrap_s    = (ctr_r == CTR_LAST);
  assign ctr_inc_s = wrap_s ? CTR_ZERO : (ctr_r + CTR_ONE);

  assign pop_s  = valid_r && i_ready;
  assign full_s = (cnt_r == CNT_FULL);
  assign push_s = push_req_s && (!full_s || pop_s);
  assign ovf_s  = push_req_s && full_s && !pop_s;

  // Synchronize the asynchronous line and arm start detection once a real high is seen
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rx_meta_r  <= 1'b1;
      rx_r       <= 1'b1;
      sync_vld_r <= 2'b00;
      armed_r    <= 1'b0;
    end else begin
      rx_meta_r  <= i_rxd;
      rx_r       <= rx_meta_r;
      sync_vld_r <= {sync_vld_r[0], 1'b1};
      if (sync_vld_r[1] && rx_r) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Frame state machine: next state, bit counter, shift register and events
  always_comb begin
    state_nxt_s = state_r;
    ctr_nxt_s   = ctr_inc_s;
    bit_nxt_s   = bit_r;
    sr_nxt_s    = sr_r;
    push_req_s  = 1'b0;
    frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt_s = par_bad_r;
    par_err_s     = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        ctr_nxt_s = CTR_ZERO;
        bit_nxt_s = 3'd0;
        if (armed_r && !rx_r) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (sample_s && rx_r) begin
          // Line went back high before mid-bit: a glitch, not a start bit
          state_nxt_s = ST_IDLE;
          ctr_nxt_s   = CTR_ZERO;
        end else if (wrap_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (sample_s) begin
          sr_nxt_s = {rx_r, sr_r[7:1]};
        end else begin
          sr_nxt_s = sr_r;
        end
        if (wrap_s) begin
          bit_nxt_s = bit_r + 3'd1;
          if (bit_r == 3'd7) begin
            state_nxt_s = ST_AFTER_DATA;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          bit_nxt_s = bit_r;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample_s) begin
          par_bad_nxt_s = parity_bad(sr_r, rx_r);
        end else begin
          par_bad_nxt_s = par_bad_r;
        end
        if (wrap_s) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (sample_s) begin
          // Leave at mid-stop so a back-to-back start edge is not missed
          ctr_nxt_s = CTR_ZERO;
          if (rx_r) begin
`ifdef UART_RX_PARITY_EN
            push_req_s = !par_bad_r;
`else
            push_req_s = 1'b1;
`endif
            state_nxt_s = ST_IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_nxt_s = ST_BRK;
          end
`ifdef UART_RX_PARITY_EN
          par_err_s = par_bad_r;
`endif
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_BRK: begin
        ctr_nxt_s = CTR_ZERO;
        if (rx_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BRK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ctr_nxt_s   = CTR_ZERO;
      end
    endcase
  end

  // FIFO pointer/count update and next head-of-queue byte
  always_comb begin
    if (pop_s) begin
      rd_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_nxt_s = rd_ptr_r;
    end
    if (push_s) begin
      wr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_nxt_s = wr_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
    if (cnt_nxt_s == CNT_ZERO) begin
      head_nxt_s = data_r;
    end else if (push_s && (wr_ptr_r == rd_nxt_s)) begin
      // Byte being written now becomes the head (FIFO was otherwise empty)
      head_nxt_s = sr_r;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // FIFO storage write
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= sr_r;
    end
  end

  // State, FIFO control and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      ctr_r       <= CTR_ZERO;
      bit_r       <= 3'd0;
      sr_r        <= 8'h00;
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      cnt_r       <= CNT_ZERO;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      ctr_r       <= ctr_nxt_s;
      bit_r       <= bit_nxt_s;
      sr_r        <= sr_nxt_s;
      wr_ptr_r    <= wr_nxt_s;
      rd_ptr_r    <= rd_nxt_s;
      cnt_r       <= cnt_nxt_s;
      data_r      <= head_nxt_s;
      valid_r     <= (cnt_nxt_s != CNT_ZERO);
      frame_err_r <= frame_err_s;
      overflow_r  <= ovf_s;
`ifdef UART_RX_PARITY_EN
      par_bad_r    <= par_bad_nxt_s;
      parity_err_r <= par_err_s;
`endif
    end
  end

  assign o_data      = data_r;
  assign o_valid     = valid_r;
  assign o_count     = cnt_r;
  assign o_frame_err = frame_err_r;
  assign o_overflow  = overflow_r;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_r;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
